// File: rtl/my_fifo8x16.sv
// my_fifo8x16: 8-entry x 16-bit synchronous FIFO, valid/ready on both sides, first-word-fall-through read.
// Latency: a word pushed at edge N is on out_data/out_valid after edge N (no in->out bypass).
// Backpressure: in_ready drops only at count==8, out_valid only at count==0; both are decoded from the count register alone.
//
// Ports:
//   clk        single clock, rising-edge
//   rst_n      synchronous active-low reset; clears pointers, count and all storage
//   flush      synchronous clear of pointers/count (storage kept); beats reset-free push/pop
//   in_data    write word,  in_valid / in_ready   producer handshake
//   out_data   word at rd_ptr (combinational), out_valid / out_ready   consumer handshake
//   count      occupancy 0..8

module my_fifo8x16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  count
);

  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  occ;
  logic [15:0] storage [8];

  logic push;
  logic pop;

  // Full/empty come only from the occupancy register: wr_ptr == rd_ptr
  // cannot tell full from empty once both pointers have wrapped.
  assign in_ready  = (occ != 4'd8);
  assign out_valid = (occ != 4'd0);
  assign count     = occ;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Pointers and occupancy. Flush discards any handshake in its cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      occ    <= 4'd0;
    end else if (flush) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      occ    <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;  // wraps 7 -> 0 naturally
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 4'd1;
        2'b01:   occ <= occ - 4'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage: cleared by reset so out_data reads 0 afterwards; flush leaves
  // the words in place (they become stale, never valid).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) storage[i] <= 16'h0000;
    end else if (!flush && push) begin
      storage[wr_ptr] <= in_data;
    end
  end

  // 8:1 read mux as a three-level 2:1 tree, rd_ptr[0] selecting at the
  // leaves so in0..in7 map to storage[0..7] in pointer order.
  logic [15:0] mux_l1 [4];
  logic [15:0] mux_l2 [2];

  for (genvar g = 0; g < 4; g++) begin : g_mux_l1
    assign mux_l1[g] = rd_ptr[0] ? storage[2*g+1] : storage[2*g];
  end

  for (genvar g = 0; g < 2; g++) begin : g_mux_l2
    assign mux_l2[g] = rd_ptr[1] ? mux_l1[2*g+1] : mux_l1[2*g];
  end

  assign out_data = rd_ptr[2] ? mux_l2[1] : mux_l2[0];

endmodule

// File: tb/tb_my_fifo8x16.sv
module tb_my_fifo8x16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [15:0] mq[$];       // reference FIFO contents, head = next word out
  logic [15:0] dut_log[$];  // words the DUT actually handed over
  logic [15:0] exp_q[$];

  my_fifo8x16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of at most 8 words.
  always @(posedge clk) begin
    int sz;
    bit m_push;
    bit m_pop;
    sz = mq.size();
    if (rst_n && !flush && out_valid && out_ready) dut_log.push_back(out_data);
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      m_pop  = (sz > 0) && out_ready;
      m_push = in_valid && (sz < 8);
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(in_data);
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(mq.size()));
      check("in_ready", 32'(in_ready), 32'(mq.size() != 8));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() > 0) check("out_data", 32'(out_data), 32'(mq[0]));
    end
  end

  // Apply inputs at a falling edge and advance to the next falling edge.
  task automatic drive(input logic rn, input logic iv, input logic [15:0] d,
                       input logic ordy, input logic fl);
    rst_n     = rn;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, 32'(dut_log.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < dut_log.size(); k++)
      check(name, 32'(dut_log[k]), 32'(exp_q[k]));
  endtask

  initial begin
    // Reset with a write attempt pending.
    drive(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'h0000);
    chk_en = 1'b1;

    // Fill to full, then a rejected 9th push.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 16'(i), 1'b0, 1'b0);
      check("fill_count", 32'(count), 32'(i));
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b1, 16'h0009, 1'b0, 1'b0);
    check("ninth_push_count", 32'(count), 32'd8);

    // Drain in order.
    dut_log.delete();
    repeat (8) drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_count", 32'(count), 32'd0);
    exp_q.delete();
    for (int k = 1; k <= 8; k++) exp_q.push_back(16'(k));
    check_log("drain_seq");

    // Wrap-around with simultaneous push/pop.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 16'(16'h0A01 + i), 1'b0, 1'b0);
    dut_log.delete();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 16'(16'h0100 + i), 1'b1, 1'b0);
      check("wrap_count", 32'(count), 32'd3);
    end
    exp_q.delete();
    exp_q.push_back(16'h0A01);
    exp_q.push_back(16'h0A02);
    exp_q.push_back(16'h0A03);
    for (int k = 0; k < 9; k++) exp_q.push_back(16'(16'h0100 + k));
    check_log("wrap_seq");
    check("wrap_head", 32'(out_data), 32'h0109);

    // Full with push+pop requested: only the pop happens.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
    check("refill_count", 32'(count), 32'd8);
    drive(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    check("full_pushpop_count", 32'(count), 32'd7);
    check("full_pushpop_in_ready", 32'(in_ready), 32'd1);
    repeat (7) drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("empty_count", 32'(count), 32'd0);
    check("empty_out_valid", 32'(out_valid), 32'd0);

    // Empty with push+pop requested: only the push happens.
    drive(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
    check("empty_pushpop_count", 32'(count), 32'd1);
    check("empty_pushpop_out_valid", 32'(out_valid), 32'd1);
    check("empty_pushpop_data", 32'(out_data), 32'h1234);

    // Flush at count 5 with push and pop also requested.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
    check("preflush_count", 32'(count), 32'd5);
    drive(1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0);
    check("postflush_data", 32'(out_data), 32'hA5A5);
    check("postflush_count", 32'(count), 32'd1);

    // Reset mid-operation loses everything, storage included.
    drive(1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0);
    check("prereset_count", 32'(count), 32'd2);
    drive(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'h0000);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
